// File: rtl/bus_fabric_if.sv
// CPU master port and flattened device-side bus of the system bus fabric.
// The slave modport is the fabric's view; master is the CPU/device-model view.
interface bus_fabric_if #(
   parameter int NUM_SLAVES = 8
);
   logic [31:0]              m_addr_i;
   logic [31:0]              m_data_i;
   logic [31:0]              m_data_o;
   logic [1:0]               m_sel_i;
   logic                     m_rd_i;
   logic                     m_we_i;
   logic                     m_ack_o;
   logic                     m_err_o;
   logic [31:0]              s_addr_o;
   logic [31:0]              s_data_o;
   logic [1:0]               s_sel_o;
   logic [NUM_SLAVES-1:0]    s_rd_o;
   logic [NUM_SLAVES-1:0]    s_we_o;
   logic [32*NUM_SLAVES-1:0] s_data_i;
   logic [NUM_SLAVES-1:0]    s_ack_i;

   modport master (
      output m_addr_i, m_data_i, m_sel_i, m_rd_i, m_we_i, s_data_i, s_ack_i,
      input  m_data_o, m_ack_o, m_err_o, s_addr_o, s_data_o, s_sel_o, s_rd_o, s_we_o
   );

   modport slave (
      input  m_addr_i, m_data_i, m_sel_i, m_rd_i, m_we_i, s_data_i, s_ack_i,
      output m_data_o, m_ack_o, m_err_o, s_addr_o, s_data_o, s_sel_o, s_rd_o, s_we_o
   );
endinterface

// File: rtl/bus_fabric.sv
// Base/mask address-window bus fabric: one CPU master to NUM_SLAVES devices,
// with registered access FSM, ack timeout, error responses and error record.
module bus_fabric #(
   parameter int                       NUM_SLAVES = 8,
   parameter logic [32*NUM_SLAVES-1:0] BASE_ADDRS = '0,
   parameter logic [32*NUM_SLAVES-1:0] ADDR_MASKS = '0,
   parameter int                       TIMEOUT    = 1024,
   parameter logic [31:0]              ERR_DATA   = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   bus_fabric_if.slave bus,
   output logic [31:0] err_addr_o,
   output logic [7:0]  err_cnt_o,
   output logic        err_irq_o,
   input  logic        err_clr_i
);
   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, RELEASE} state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rd_q, rd_d;
   logic [31:0]           m_data_q, m_data_d;
   logic                  m_ack_q, m_ack_d;
   logic                  m_err_q, m_err_d;
   logic [31:0]           s_addr_q, s_addr_d;
   logic [31:0]           s_data_q, s_data_d;
   logic [1:0]            s_sel_q, s_sel_d;
   logic [NUM_SLAVES-1:0] s_rd_q, s_rd_d;
   logic [NUM_SLAVES-1:0] s_we_q, s_we_d;
   logic [31:0]           err_addr_q, err_addr_d;
   logic [7:0]            err_cnt_q, err_cnt_d;
   logic                  err_irq_q, err_irq_d;

   logic                  hit;
   logic [IDX_W-1:0]      hit_idx;
   logic [31:0]           hit_mask;
   logic                  req, go_resp, resp_err;

   assign req = bus.m_rd_i ^ bus.m_we_i;

   // Scan downward so the lowest matching window overwrites higher ones.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      hit_mask = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((bus.m_addr_i & ADDR_MASKS[32*i +: 32]) ==
             (BASE_ADDRS[32*i +: 32] & ADDR_MASKS[32*i +: 32])) begin
            hit      = 1'b1;
            hit_idx  = IDX_W'(i);
            hit_mask = ADDR_MASKS[32*i +: 32];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      m_data_d   = m_data_q;
      m_ack_d    = 1'b0;
      m_err_d    = 1'b0;
      s_addr_d   = s_addr_q;
      s_data_d   = s_data_q;
      s_sel_d    = s_sel_q;
      s_rd_d     = s_rd_q;
      s_we_d     = s_we_q;
      err_addr_d = err_addr_q;
      err_cnt_d  = err_cnt_q;
      err_irq_d  = err_irq_q;
      go_resp    = 1'b0;
      resp_err   = 1'b0;

      case (state_q)
         IDLE: begin
            if ((bus.m_rd_i && bus.m_we_i) || (req && !hit)) begin
               rd_d     = bus.m_rd_i;
               go_resp  = 1'b1;
               resp_err = 1'b1;
            end else if (req) begin
               idx_d            = hit_idx;
               cnt_d            = CNT_W'(1);
               rd_d             = bus.m_rd_i;
               s_addr_d         = bus.m_addr_i & ~hit_mask;
               s_data_d         = bus.m_data_i;
               s_sel_d          = bus.m_sel_i;
               s_rd_d           = '0;
               s_we_d           = '0;
               s_rd_d[hit_idx]  = bus.m_rd_i;
               s_we_d[hit_idx]  = bus.m_we_i;
               state_d          = ACCESS;
            end
         end
         ACCESS: begin
            // Ack is tested before the counter so a same-cycle ack wins.
            if (bus.s_ack_i[idx_q]) begin
               s_rd_d  = '0;
               s_we_d  = '0;
               go_resp = 1'b1;
               if (rd_q) m_data_d = bus.s_data_i[32*idx_q +: 32];
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               s_rd_d   = '0;
               s_we_d   = '0;
               go_resp  = 1'b1;
               resp_err = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP:    state_d = RELEASE;
         RELEASE: if (!bus.m_rd_i && !bus.m_we_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (go_resp) begin
         state_d = RESP;
         m_ack_d = 1'b1;
         m_err_d = resp_err;
         if (resp_err && rd_d) m_data_d = ERR_DATA;
      end

      // A coincident clear is applied before the new error is recorded.
      if (err_clr_i) begin
         err_cnt_d = '0;
         err_irq_d = 1'b0;
      end
      if (go_resp && resp_err) begin
         if (err_cnt_d != 8'hFF) err_cnt_d = err_cnt_d + 8'd1;
         if (!err_irq_d) begin
            err_addr_d = bus.m_addr_i;
            err_irq_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         rd_q       <= 1'b0;
         m_data_q   <= '0;
         m_ack_q    <= 1'b0;
         m_err_q    <= 1'b0;
         s_addr_q   <= '0;
         s_data_q   <= '0;
         s_sel_q    <= '0;
         s_rd_q     <= '0;
         s_we_q     <= '0;
         err_addr_q <= '0;
         err_cnt_q  <= '0;
         err_irq_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         m_data_q   <= m_data_d;
         m_ack_q    <= m_ack_d;
         m_err_q    <= m_err_d;
         s_addr_q   <= s_addr_d;
         s_data_q   <= s_data_d;
         s_sel_q    <= s_sel_d;
         s_rd_q     <= s_rd_d;
         s_we_q     <= s_we_d;
         err_addr_q <= err_addr_d;
         err_cnt_q  <= err_cnt_d;
         err_irq_q  <= err_irq_d;
      end
   end

   assign bus.m_data_o = m_data_q;
   assign bus.m_ack_o  = m_ack_q;
   assign bus.m_err_o  = m_err_q;
   assign bus.s_addr_o = s_addr_q;
   assign bus.s_data_o = s_data_q;
   assign bus.s_sel_o  = s_sel_q;
   assign bus.s_rd_o   = s_rd_q;
   assign bus.s_we_o   = s_we_q;
   assign err_addr_o   = err_addr_q;
   assign err_cnt_o    = err_cnt_q;
   assign err_irq_o    = err_irq_q;
endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: reactive device models drive acks, a
// window-table reference model predicts every response and error record.
module tb_bus_fabric;
   localparam int          NS   = 8;
   localparam int          TMO  = 16;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
   localparam logic [32*NS-1:0] BASE_FLAT = {
      32'hE000_0000, 32'h1000_0000, 32'h1000_0000, 32'hC000_0000,
      32'hA000_0000, 32'hBFC0_0000, 32'h9000_0000, 32'h8000_0000};
   localparam logic [32*NS-1:0] MASK_FLAT = {
      32'hF000_0000, 32'hFFF0_0000, 32'hFF00_0000, 32'hFFFF_FF00,
      32'hFF00_0000, 32'hFFF0_0000, 32'hFFFF_F000, 32'hFFFF_0000};

   typedef struct {
      int          cyc;
      logic        err;
      logic [31:0] data;
      logic [31:0] eaddr;
      logic [7:0]  ecnt;
      logic        eirq;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        err_clr_i;
   logic [31:0] err_addr_o;
   logic [7:0]  err_cnt_o;
   logic        err_irq_o;
   int          cyc;
   int          n_tests;
   int          n_fail;
   exp_t        exp_q[$];
   exp_t        me;
   logic [31:0] mdl_data;
   logic [31:0] mdl_addr;
   int          mdl_cnt;
   bit          mdl_irq;

   bus_fabric_if #(.NUM_SLAVES(NS)) bus ();

   bus_fabric #(
      .NUM_SLAVES(NS), .BASE_ADDRS(BASE_FLAT), .ADDR_MASKS(MASK_FLAT),
      .TIMEOUT(TMO), .ERR_DATA(ERRD)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o),
      .err_irq_o(err_irq_o), .err_clr_i(err_clr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   function automatic logic [31:0] base_of(input int i);
      return BASE_FLAT[32*i +: 32];
   endfunction

   function automatic logic [31:0] mask_of(input int i);
      return MASK_FLAT[32*i +: 32];
   endfunction

   // Window table lookup: first (lowest) matching window, -1 when unmapped.
   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < NS; i++)
         if ((a & mask_of(i)) == (base_of(i) & mask_of(i))) return i;
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic do_txn(input logic [31:0] addr, input logic rd, input logic we,
                         input logic [31:0] wdata, input logic [1:0] sel,
                         input logic [31:0] rdata, input int d, input int hold,
                         input bit clr_co, input bit late);
      int              idx, lat, nstb, req_cyc;
      logic [NS-1:0]   onehot, strb, stb_now;
      logic [32*NS-1:0] lanes;
      exp_t            e;
      idx    = (rd ^ we) ? decode(addr) : -1;
      onehot = '0;
      if (idx >= 0) onehot[idx] = 1'b1;
      nstb = (idx < 0) ? 0 : ((d == 0) ? TMO : d);
      lat  = (idx < 0) ? 1 : nstb + 1;
      for (int k = 0; k < NS; k++) lanes[32*k +: 32] = $urandom;
      if (idx >= 0) lanes[32*idx +: 32] = rdata;

      if (clr_co) begin
         mdl_cnt = 0;
         mdl_irq = 1'b0;
      end
      if (idx < 0 || d == 0) begin
         e.err = 1'b1;
         if (rd) mdl_data = ERRD;
         if (mdl_cnt != 255) mdl_cnt++;
         if (!mdl_irq) begin
            mdl_irq  = 1'b1;
            mdl_addr = addr;
         end
      end else begin
         e.err = 1'b0;
         if (rd) mdl_data = rdata;
      end
      e.data  = mdl_data;
      e.eaddr = mdl_addr;
      e.ecnt  = 8'(mdl_cnt);
      e.eirq  = mdl_irq;

      bus.s_data_i = lanes;
      bus.m_addr_i = addr;
      bus.m_data_i = wdata;
      bus.m_sel_i  = sel;
      bus.m_rd_i   = rd;
      bus.m_we_i   = we;
      err_clr_i    = clr_co && (lat == 1);
      req_cyc      = cyc;
      e.cyc        = req_cyc + lat;
      exp_q.push_back(e);

      for (int n = 1; n <= lat + hold + 2; n++) begin
         @(posedge clk);
         #1;
         err_clr_i = clr_co && (n == lat - 1);
         strb = (n <= nstb) ? onehot : '0;
         chk("s_rd_o", bus.s_rd_o, rd ? strb : '0);
         chk("s_we_o", bus.s_we_o, we ? strb : '0);
         if (n == 1 && idx >= 0) begin
            chk("s_addr_o", bus.s_addr_o, addr & ~mask_of(idx));
            chk("s_data_o", bus.s_data_o, wdata);
            chk("s_sel_o", bus.s_sel_o, sel);
         end
         stb_now     = bus.s_rd_o | bus.s_we_o;
         bus.s_ack_i = NS'($urandom) & ~stb_now;
         if (d > 0 && n == d) bus.s_ack_i = bus.s_ack_i | stb_now;
         if (late && n == lat + 1) bus.s_ack_i = onehot;
         if (n == lat + hold) begin
            bus.m_rd_i = 1'b0;
            bus.m_we_i = 1'b0;
         end
      end
      bus.s_ack_i = '0;
      err_clr_i   = 1'b0;
   endtask

   task automatic clr_pulse();
      err_clr_i = 1'b1;
      @(posedge clk);
      #1;
      err_clr_i = 1'b0;
      mdl_cnt   = 0;
      mdl_irq   = 1'b0;
      chk("clr_irq", err_irq_o, 0);
      chk("clr_cnt", err_cnt_o, 0);
      chk("clr_addr_kept", err_addr_o, mdl_addr);
   endtask

   // Scoreboard monitor: every m_ack_o consumes one predicted response.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.m_ack_o) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_ack: m_ack_o=1 at cycle %0d, required 0", cyc);
               end else begin
                  me = exp_q.pop_front();
                  chk("ack_cycle", cyc, me.cyc);
                  chk("m_err_o", bus.m_err_o, me.err);
                  chk("m_data_o", bus.m_data_o, me.data);
                  chk("err_addr_o", err_addr_o, me.eaddr);
                  chk("err_cnt_o", err_cnt_o, me.ecnt);
                  chk("err_irq_o", err_irq_o, me.eirq);
               end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
               me = exp_q.pop_front();
               n_tests++;
               n_fail++;
               $display("FAIL missing_ack: none by cycle %0d, required at cycle %0d", cyc, me.cyc);
            end
         end
      end
   end

   initial begin
      int          kind, k, d;
      logic [31:0] a;
      logic        r, w;
      n_tests      = 0;
      n_fail       = 0;
      rst          = 1'b1;
      err_clr_i    = 1'b0;
      bus.m_addr_i = '0;
      bus.m_data_i = '0;
      bus.m_sel_i  = '0;
      bus.m_rd_i   = 1'b0;
      bus.m_we_i   = 1'b0;
      bus.s_data_i = '0;
      bus.s_ack_i  = '0;
      mdl_data     = '0;
      mdl_addr     = '0;
      mdl_cnt      = 0;
      mdl_irq      = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_ack_o", bus.m_ack_o, 0);
      chk("rst_m_err_o", bus.m_err_o, 0);
      chk("rst_m_data_o", bus.m_data_o, 0);
      chk("rst_s_rd_o", bus.s_rd_o, 0);
      chk("rst_s_we_o", bus.s_we_o, 0);
      chk("rst_s_addr_o", bus.s_addr_o, 0);
      chk("rst_s_data_o", bus.s_data_o, 0);
      chk("rst_s_sel_o", bus.s_sel_o, 0);
      chk("rst_err_addr_o", err_addr_o, 0);
      chk("rst_err_cnt_o", err_cnt_o, 0);
      chk("rst_err_irq_o", err_irq_o, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_txn(32'hBFC0_0010, 1'b1, 1'b0, 32'h0, 2'd2, 32'h1234_5678, 3, 0, 1'b0, 1'b0);
      do_txn(32'h8000_0004, 1'b0, 1'b1, 32'h5A5A_5A5A, 2'd3, 32'h0, 1, 3, 1'b0, 1'b0);
      do_txn(32'h0000_0040, 1'b1, 1'b0, 32'h0, 2'd0, 32'h0, 1, 0, 1'b0, 1'b0);
      do_txn(32'hA000_0100, 1'b1, 1'b0, 32'h0, 2'd2, 32'h0, 0, 0, 1'b0, 1'b1);
      do_txn(32'h1000_1234, 1'b1, 1'b0, 32'h0, 2'd1, 32'hCAFE_F00D, 2, 0, 1'b0, 1'b0);
      do_txn(32'h8000_0000, 1'b1, 1'b1, 32'h1111_2222, 2'd0, 32'h0, 1, 0, 1'b0, 1'b0);
      do_txn(32'h0000_0044, 1'b0, 1'b1, 32'h0, 2'd0, 32'h0, 1, 0, 1'b1, 1'b0);
      do_txn(32'hC000_0010, 1'b1, 1'b0, 32'h0, 2'd2, 32'h0, 0, 1, 1'b1, 1'b0);
      clr_pulse();

      bus.m_addr_i = 32'hBFC0_0020;
      bus.m_rd_i   = 1'b1;
      bus.m_we_i   = 1'b0;
      bus.s_ack_i  = '0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("rst_mid_strobe_before", bus.s_rd_o, 8'b0000_0100);
      rst        = 1'b1;
      bus.m_rd_i = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_s_rd_o", bus.s_rd_o, 0);
      chk("rst_mid_s_we_o", bus.s_we_o, 0);
      chk("rst_mid_m_ack_o", bus.m_ack_o, 0);
      rst      = 1'b0;
      mdl_data = '0;
      mdl_addr = '0;
      mdl_cnt  = 0;
      mdl_irq  = 1'b0;
      repeat (TMO + 4) begin
         @(posedge clk);
         #1;
      end
      chk("rst_mid_err_cnt_o", err_cnt_o, 0);
      chk("rst_mid_err_irq_o", err_irq_o, 0);
      do_txn(32'hBFC0_0024, 1'b1, 1'b0, 32'h0, 2'd2, 32'h0BAD_F00D, 2, 0, 1'b0, 1'b0);

      for (int t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 9);
         k    = $urandom_range(0, NS - 1);
         if (kind <= 6) a = base_of(k) | ($urandom & ~mask_of(k));
         else           a = $urandom;
         if (kind == 8) begin
            r = 1'b1;
            w = 1'b1;
         end else begin
            r = 1'($urandom_range(0, 1));
            w = !r;
         end
         d = $urandom_range(0, 6);
         do_txn(a, r, w, $urandom, 2'($urandom_range(0, 3)), $urandom, d,
                $urandom_range(0, 2), ($urandom_range(0, 5) == 0), (d == 0));
         if ($urandom_range(0, 7) == 0) clr_pulse();
      end

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised successor to the fixed per-device system bus decoder.
- Connects the CPU's single 32-bit bus master port to NUM_SLAVES device ports through a table of base/mask address windows.
- Adds behaviour the fixed decoder lacks: a registered access state machine, a slave-ack timeout, error responses for unmapped or malformed accesses, and a latched error record with interrupt.
- Sits between the CPU bus port and the GPU, BIOS, flash, timer, UART, PS/2, switch and datetime devices.

Parameters:
NUM_SLAVES, 8, number of slave ports (1..16)
BASE_ADDRS, 0, flattened 32*NUM_SLAVES vector; slave i's base is bits [32i+31:32i]
ADDR_MASKS, 0, flattened 32*NUM_SLAVES vector; a 1 bit means the bit is decoded, a 0 bit means it is an offset bit
TIMEOUT, 1024, maximum cycles in ACCESS before a forced error response (>=2)
ERR_DATA, 32'hDEAD_BEEF, read data returned on any error response

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m_addr_i  in  32  master address, held stable while m_rd_i or m_we_i is high
m_data_i  in  32  master write data
m_data_o  out  32  read data, valid in the cycle m_ack_o is high, held until the next response
m_sel_i  in  2  access size code, passed through unchanged
m_rd_i  in  1  read request level
m_we_i  in  1  write request level
m_ack_o  out  1  one-cycle completion pulse
m_err_o  out  1  high together with m_ack_o when the access failed
s_addr_o  out  32  offset address: m_addr_i & ~mask of the selected slave
s_data_o  out  32  write data, broadcast to all slaves
s_sel_o  out  2  size code, broadcast to all slaves
s_rd_o  out  NUM_SLAVES  one-hot read strobes
s_we_o  out  NUM_SLAVES  one-hot write strobes
s_data_i  in  32*NUM_SLAVES  slave read data, flattened
s_ack_i  in  NUM_SLAVES  slave acknowledges
err_addr_o  out  32  address of the first unreported error
err_cnt_o  out  8  saturating error count
err_irq_o  out  1  level interrupt, high while an error is pending
err_clr_i  in  1  pulse; clears err_irq_o and err_cnt_o

Behaviour:
- Reset: state IDLE; all outputs 0 (m_data_o, s_*, err_addr_o, err_cnt_o, m_ack_o, m_err_o, err_irq_o). Reset mid-access drops the strobes at the same edge; no ack is produced.
- Decode: slave i hits when (m_addr_i & MASK_i) == (BASE_i & MASK_i). If several slaves hit, the lowest index wins. Unregistered decode is evaluated in IDLE only.
- States: IDLE, ACCESS, RESP, RELEASE.
- IDLE, request = m_rd_i ^ m_we_i:
  - Request with a hit: register the index, s_addr_o, s_data_o and s_sel_o; raise s_rd_o[i] or s_we_o[i]; go to ACCESS.
  - Request with no hit, or m_rd_i and m_we_i both high: go to RESP with error set.
- ACCESS:
  - Strobe held.
  - The timeout counter counts from 1 in the first ACCESS cycle.
  - s_ack_i[i] high: capture s_data_i[i] (reads only), drop the strobe, go to RESP with no error.
  - Counter reaches TIMEOUT without ack: drop the strobe, go to RESP with error set.
  - Ack and timeout in the same cycle: ack wins.
  - Acks from non-selected slaves are ignored.
- RESP: m_ack_o = 1 for exactly one cycle.
  - m_err_o = error flag.
  - On a read error, m_data_o = ERR_DATA. On a write, m_data_o is unchanged.
  - Then go to RELEASE.
- RELEASE: stay until m_rd_i = m_we_i = 0, then go to IDLE. No new request is accepted before release.
- Minimum latency, request to ack:
  - Mapped access with slave acking on the first ACCESS cycle: 2 cycles.
  - Unmapped access: 1 cycle.
- Error record, updated at every RESP with error:
  - err_cnt_o increments, saturating at 255.
  - If err_irq_o is low: latch m_addr_i into err_addr_o and set err_irq_o.
  - If err_irq_o is already high: err_addr_o is kept.
  - err_clr_i in the same cycle as a new error: the clear applies first, then the new error is recorded (irq = 1, cnt = 1, addr = new).

Test Plan:
- Slave 2 window 0xBFC0_0000 with mask 0xFFF0_0000; read 0xBFC0_0010; slave acks after 3 cycles with 0x1234_5678 -> s_rd_o = 0b0000_0100, s_addr_o = 0x10, m_ack_o pulses at request + 4, m_data_o = 0x1234_5678, m_err_o = 0.
- Write 0x5A5A_5A5A to a mapped slave that acks immediately -> s_we_o one-hot, s_data_o = 0x5A5A_5A5A, ack 2 cycles after request; request held 3 extra cycles -> no second strobe until released.
- Read an unmapped address 0x0000_0040 -> ack + err 1 cycle later, m_data_o = 0xDEAD_BEEF, err_addr_o = 0x40, err_irq_o = 1, err_cnt_o = 1.
- TIMEOUT = 16, slave never acks -> strobe high exactly 16 cycles, then ack + err; a late slave ack after that is ignored.
- Two overlapping windows -> lower index selected. m_rd_i = m_we_i = 1 -> error response with no strobe. err_clr_i coincident with an error -> cnt = 1, irq = 1.
- Assert rst during ACCESS -> strobes low after the edge, no m_ack_o; the next request completes normally.
